// File: rtl/text_scanout.sv
// Text-mode raster scanout: raster timing, text buffer fetch, character_rom drive and a
// 3-cycle aligned pixel/sync/blank stream with a blinking underline cursor.
module text_scanout #(
   parameter int COLUMNS      = 40,
   parameter int ROWS         = 25,
   parameter int H_FRONT      = 16,
   parameter int H_SYNC       = 32,
   parameter int H_BACK       = 32,
   parameter int V_FRONT      = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BACK       = 50,
   parameter int BLINK_FRAMES = 30
) (
   input  logic       clock,
   input  logic       reset_n,
   output logic [9:0] text_address,
   input  logic [6:0] text_data,
   output logic [6:0] character,
   output logic [2:0] x,
   output logic [2:0] y,
   input  logic       dot,
   input  logic       cursor_enable,
   input  logic [5:0] cursor_column,
   input  logic [4:0] cursor_row,
   output logic       pixel,
   output logic       hsync_n,
   output logic       vsync_n,
   output logic       display_enable,
   output logic       frame_start
);
   localparam int H_TOTAL = COLUMNS*8 + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = ROWS*8 + V_FRONT + V_SYNC + V_BACK;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(COLUMNS*8);
   localparam logic [HW-1:0] HS_START = HW'(COLUMNS*8 + H_FRONT);
   localparam logic [HW-1:0] HS_END   = HW'(COLUMNS*8 + H_FRONT + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(ROWS*8);
   localparam logic [VW-1:0] VS_START = VW'(ROWS*8 + V_FRONT);
   localparam logic [VW-1:0] VS_END   = VW'(ROWS*8 + V_FRONT + V_SYNC);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic [9:0]    row_base;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;
   logic          h_last, v_last;

   logic vld_p0, hs_p0, vs_p0, fs_p0, cur_p0;
   logic vld_p1, hs_p1, vs_p1, fs_p1, cur_p1;
   logic vld_p2, hs_p2, vs_p2, fs_p2, cur_p2;

   assign h_last = (h == H_LAST);
   assign v_last = (v == V_LAST);

   // S0: raster counters, running row base and blink state
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         h           <= '0;
         v           <= '0;
         row_base    <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + 1'b1;
            // Row base advances when the next line starts a new text row.
            if (v_last)
               row_base <= '0;
            else if (v[2:0] == 3'd7 && v < V_ACT)
               row_base <= row_base + 10'(COLUMNS);
            if (v_last) begin
               if (blink_cnt == BLINK_LAST) begin
                  blink_cnt   <= '0;
                  blink_phase <= ~blink_phase;
               end else begin
                  blink_cnt <= blink_cnt + 1'b1;
               end
            end
         end else begin
            h <= h + 1'b1;
         end
      end
   end

   assign vld_p0 = (h < H_ACT) && (v < V_ACT);
   assign hs_p0  = (h >= HS_START) && (h < HS_END);
   assign vs_p0  = (v >= VS_START) && (v < VS_END);
   assign fs_p0  = (h == '0) && (v == '0);
   // Gating by the active area also hides out-of-range cursor coordinates.
   assign cur_p0 = cursor_enable && blink_phase && vld_p0 && (v[2:0] == 3'd7) &&
                   (10'(h >> 3) == 10'(cursor_column)) && (10'(v >> 3) == 10'(cursor_row));
   assign text_address = vld_p0 ? row_base + 10'(h >> 3) : '0;

   // S1: glyph coordinates to character_rom, text_data arrives
   assign character = text_data;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         x      <= '0;
         y      <= '0;
         vld_p1 <= 1'b0;
         hs_p1  <= 1'b0;
         vs_p1  <= 1'b0;
         fs_p1  <= 1'b0;
         cur_p1 <= 1'b0;
      end else begin
         x      <= h[2:0];
         y      <= v[2:0];
         vld_p1 <= vld_p0;
         hs_p1  <= hs_p0;
         vs_p1  <= vs_p0;
         fs_p1  <= fs_p0;
         cur_p1 <= cur_p0;
      end
   end

   // S2: dot valid from character_rom
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_p2 <= 1'b0;
         hs_p2  <= 1'b0;
         vs_p2  <= 1'b0;
         fs_p2  <= 1'b0;
         cur_p2 <= 1'b0;
      end else begin
         vld_p2 <= vld_p1;
         hs_p2  <= hs_p1;
         vs_p2  <= vs_p1;
         fs_p2  <= fs_p1;
         cur_p2 <= cur_p1;
      end
   end

   // S3: output registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pixel          <= 1'b0;
         display_enable <= 1'b0;
         hsync_n        <= 1'b1;
         vsync_n        <= 1'b1;
         frame_start    <= 1'b0;
      end else begin
         pixel          <= vld_p2 & (dot ^ cur_p2);
         display_enable <= vld_p2;
         hsync_n        <= ~hs_p2;
         vsync_n        <= ~vs_p2;
         frame_start    <= fs_p2;
      end
   end

endmodule

// File: tb/tb_text_scanout.sv
// Bench for text_scanout: RAM/ROM models plus a raster-position reference model.
module tb_text_scanout;
   localparam int C = 40, R = 4, HF = 16, HS = 32, HB = 32, VF = 2, VS = 2, VB = 2, BF = 2;
   localparam int HA = C*8, HT = HA + HF + HS + HB, VA = R*8, VT = VA + VF + VS + VB;
   localparam int FT = HT*VT;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [9:0] text_address;
   logic [6:0] text_data = 7'd0;
   logic [6:0] character;
   logic [2:0] x, y;
   logic       dot = 1'b0;
   logic       cursor_enable = 1'b1;
   logic [5:0] cursor_column = 6'd2;
   logic [4:0] cursor_row = 5'd1;
   logic       pixel, hsync_n, vsync_n, display_enable, frame_start;
   logic       force_dot = 1'b0;
   logic [6:0] ram [1024];

   int checks = 0;
   int errors = 0;
   int t = 0;

   always #5 clock = ~clock;

   text_scanout #(.COLUMNS(C), .ROWS(R), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                  .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .BLINK_FRAMES(BF)) dut (
      .clock(clock), .reset_n(reset_n), .text_address(text_address), .text_data(text_data),
      .character(character), .x(x), .y(y), .dot(dot), .cursor_enable(cursor_enable),
      .cursor_column(cursor_column), .cursor_row(cursor_row), .pixel(pixel),
      .hsync_n(hsync_n), .vsync_n(vsync_n), .display_enable(display_enable),
      .frame_start(frame_start));

   function automatic logic [7:0] glyph_a(input logic [2:0] r);
      case (r)
         3'd0: return 8'h18;
         3'd1: return 8'h3C;
         3'd2: return 8'h66;
         3'd3: return 8'h66;
         3'd4: return 8'h7E;
         3'd5: return 8'h66;
         3'd6: return 8'h66;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic rom_bit(input logic [6:0] c, input logic [2:0] r, input logic [2:0] col);
      logic [7:0] row;
      if (c == 7'd65) row = glyph_a(r);
      else row = {1'b0, c} * 8'd29 + {5'b0, r} * 8'd53 + 8'd17;
      return row[3'd7 - col];
   endfunction

   always @(posedge clock) text_data <= ram[text_address];
   always @(posedge clock) dot <= force_dot | rom_bit(character, y, x);

   // Reference model: everything derived from the raster index n since reset release.
   function automatic int m_addr(input int n);
      int h = n % HT;
      int v = (n / HT) % VT;
      return (h < HA && v < VA) ? (v / 8) * C + h / 8 : 0;
   endfunction

   function automatic logic m_pixel(input int n);
      int h = n % HT;
      int v = (n / HT) % VT;
      int f = n / FT;
      logic d, cur;
      if (!(h < HA && v < VA)) return 1'b0;
      d = rom_bit(ram[(v / 8) * C + h / 8], 3'(v % 8), 3'(h % 8));
      cur = cursor_enable && ((f / BF) % 2 == 1) && (h / 8 == int'(cursor_column)) &&
            (v / 8 == int'(cursor_row)) && (v % 8 == 7);
      return d ^ cur;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
      t++;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      t = 0;
   endtask

   task automatic test_reset();
      logic [22:0] obs;
      repeat (3) @(posedge clock);
      #1;
      obs = {pixel, display_enable, hsync_n, vsync_n, frame_start, x, y, text_address};
      checks++;
      if (obs !== {5'b00110, 3'd0, 3'd0, 10'd0}) begin
         errors++;
         $display("FAIL reset_hold: got %b want %b", obs, {5'b00110, 3'd0, 3'd0, 10'd0});
      end
      reset_n = 1'b1;
      t = 0;
      repeat (150) tick();
      #2 reset_n = 1'b0;
      #1;
      obs = {pixel, display_enable, hsync_n, vsync_n, frame_start, x, y, text_address};
      checks++;
      if (obs !== {5'b00110, 3'd0, 3'd0, 10'd0}) begin
         errors++;
         $display("FAIL reset_async: got %b want %b", obs, {5'b00110, 3'd0, 3'd0, 10'd0});
      end
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      t = 0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         checks++;
         if (frame_start !== (t == 3)) begin
            errors++;
            $display("FAIL reset_frame_start t=%0d: got %b want %b", t, frame_start, (t == 3));
         end
         checks++;
         if (display_enable !== (t >= 3)) begin
            errors++;
            $display("FAIL reset_display_enable t=%0d: got %b want %b", t, display_enable, (t >= 3));
         end
      end
   endtask

   task automatic test_first_char();
      logic [7:0] g;
      g = glyph_a(3'd0);
      do_reset();
      checks++;
      if (text_address !== 10'd0) begin
         errors++;
         $display("FAIL first_addr0: got %0d want 0", text_address);
      end
      for (int k = 1; k <= 48; k++) begin
         tick();
         if (t <= 8) begin
            checks++;
            if (x !== 3'(t - 1) || y !== 3'd0) begin
               errors++;
               $display("FAIL first_xy t=%0d: got x=%0d y=%0d want x=%0d y=0", t, x, y, t - 1);
            end
         end
         if (t == 1) begin
            checks++;
            if (character !== 7'd65) begin
               errors++;
               $display("FAIL first_character: got %0d want 65", character);
            end
         end
         checks++;
         if (character !== ram[m_addr(t - 1)] || text_address !== 10'(m_addr(t))) begin
            errors++;
            $display("FAIL first_fetch t=%0d: got char=%0d addr=%0d want char=%0d addr=%0d",
                     t, character, text_address, ram[m_addr(t - 1)], m_addr(t));
         end
         if (t >= 3 && t <= 10) begin
            checks++;
            if (pixel !== g[10 - t]) begin
               errors++;
               $display("FAIL first_glyph_a t=%0d: got %b want %b", t, pixel, g[10 - t]);
            end
         end
         if (t >= 3) begin
            checks++;
            if (pixel !== m_pixel(t - 3)) begin
               errors++;
               $display("FAIL first_pixel t=%0d: got %b want %b", t, pixel, m_pixel(t - 3));
            end
         end
      end
   endtask

   task automatic test_line8();
      while (t < 8 * HT) tick();
      for (int k = 0; k < HT; k++) begin
         if (k == 0 || k == 8 || k == 16) begin
            checks++;
            if (text_address !== 10'(40 + k / 8)) begin
               errors++;
               $display("FAIL line8_addr h=%0d: got %0d want %0d", k, text_address, 40 + k / 8);
            end
         end
         if (k >= HA) begin
            checks++;
            if (text_address !== 10'd0) begin
               errors++;
               $display("FAIL line8_addr_blank h=%0d: got %0d want 0", k, text_address);
            end
         end
         if (k == 322 || k == 323) begin
            checks++;
            if (display_enable !== (k == 322)) begin
               errors++;
               $display("FAIL line8_de_edge k=%0d: got %b want %b", k, display_enable, (k == 322));
            end
         end
         if (k >= 324) begin
            checks++;
            if (pixel !== 1'b0 || display_enable !== 1'b0) begin
               errors++;
               $display("FAIL line8_blank_forced k=%0d: got pixel=%b de=%b want 0 0",
                        k, pixel, display_enable);
            end
         end
         if (k == 322) force_dot = 1'b1;
         if (k == 398) force_dot = 1'b0;
         tick();
      end
   endtask

   task automatic test_sync_timing();
      logic prev;
      int   f1, f2, cnt;
      bit   seen;
      seen = 0;
      prev = hsync_n;
      for (int k = 0; k < 2 * HT && !seen; k++) begin
         tick();
         if (prev && !hsync_n) seen = 1;
         prev = hsync_n;
      end
      checks++;
      if (!seen || (t - 3) % HT != HA + HF) begin
         errors++;
         $display("FAIL hsync_start: got seen=%0d h=%0d want h=%0d", seen, (t - 3) % HT, HA + HF);
      end
      f1 = t;
      cnt = 0;
      for (int k = 0; k < HT && !hsync_n; k++) begin
         cnt++;
         tick();
      end
      checks++;
      if (cnt != HS) begin
         errors++;
         $display("FAIL hsync_width: got %0d want %0d", cnt, HS);
      end
      seen = 0;
      prev = hsync_n;
      for (int k = 0; k < 2 * HT && !seen; k++) begin
         tick();
         if (prev && !hsync_n) seen = 1;
         prev = hsync_n;
      end
      f2 = t;
      checks++;
      if (!seen || f2 - f1 != HT) begin
         errors++;
         $display("FAIL hsync_period: got %0d want %0d", f2 - f1, HT);
      end
      seen = 0;
      prev = vsync_n;
      for (int k = 0; k < FT && !seen; k++) begin
         tick();
         if (prev && !vsync_n) seen = 1;
         prev = vsync_n;
      end
      checks++;
      if (!seen || t != (VA + VF) * HT + 3) begin
         errors++;
         $display("FAIL vsync_start: got seen=%0d t=%0d want t=%0d", seen, t, (VA + VF) * HT + 3);
      end
      cnt = 0;
      for (int k = 0; k < 4 * VS * HT && !vsync_n; k++) begin
         cnt++;
         tick();
      end
      checks++;
      if (cnt != VS * HT) begin
         errors++;
         $display("FAIL vsync_width: got %0d want %0d", cnt, VS * HT);
      end
      seen = 0;
      for (int k = 0; k < FT && !seen; k++) begin
         tick();
         if (frame_start) seen = 1;
      end
      checks++;
      if (!seen || t != FT + 3) begin
         errors++;
         $display("FAIL frame_period: got seen=%0d t=%0d want t=%0d", seen, t, FT + 3);
      end
   endtask

   task automatic test_cursor();
      int inv1, inv2, inv3, n, h, v, f;
      inv1 = 0;
      inv2 = 0;
      inv3 = 0;
      while (t < 3 * FT + 16 * HT + 3) begin
         tick();
         n = t - 3;
         h = n % HT;
         v = (n / HT) % VT;
         f = n / FT;
         if (f == 2 && v == VA + 2) cursor_column = 6'd50;
         if (v >= 8 && v < 16 && h < 40) begin
            checks++;
            if (pixel !== m_pixel(n)) begin
               errors++;
               $display("FAIL cursor_pixel f=%0d v=%0d h=%0d: got %b want %b", f, v, h, pixel, m_pixel(n));
            end
            if (v == 15 && pixel !== rom_bit(ram[C + h / 8], 3'd7, 3'(h % 8))) begin
               if (f == 1) inv1++;
               if (f == 2) inv2++;
               if (f == 3) inv3++;
            end
         end
      end
      checks++;
      if (inv1 != 0 || inv2 != 8 || inv3 != 0) begin
         errors++;
         $display("FAIL cursor_inverted_counts: got %0d/%0d/%0d want 0/8/0", inv1, inv2, inv3);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic prev;
      bit   seen;
      int   tf;
      for (int k = 0; k < 10 * HT && !((t / HT) % VT == 20 && t % HT == 100); k++) tick();
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (vsync_n !== 1'b1 || text_address !== 10'd0) begin
         errors++;
         $display("FAIL midframe_reset: got vsync_n=%b addr=%0d want 1 0", vsync_n, text_address);
      end
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      t = 0;
      seen = 0;
      tf = 0;
      prev = vsync_n;
      for (int k = 0; k < FT && !seen; k++) begin
         tick();
         if (t == 3) begin
            checks++;
            if (frame_start !== 1'b1) begin
               errors++;
               $display("FAIL midframe_frame_start: got %b want 1", frame_start);
            end
         end
         if (prev && !vsync_n) begin
            seen = 1;
            tf = t;
         end
         prev = vsync_n;
      end
      checks++;
      if (!seen || tf != 3 + (VA + VF) * HT) begin
         errors++;
         $display("FAIL midframe_vsync: got seen=%0d t=%0d want t=%0d", seen, tf, 3 + (VA + VF) * HT);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 7'($urandom_range(0, 127));
      ram[0] = 7'd65;
      test_reset();
      test_first_char();
      test_line8();
      test_sync_timing();
      test_cursor();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
